// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the program-counter stage: reset default,
// run/halt state encoding and the next-PC source select.
package pc_next_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_HALT = 1'b1;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC datapath: sequential, branch, J-type and register
// targets, with the final source picked by the select from the control logic.
module pc_target_calc
  import pc_next_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_sel_e     sel,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // Candidate targets; all arithmetic wraps modulo 2^32 and the immediate
  // is a word offset, so its top two bits simply fall off the shift.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_target = pc_plus4 + (imm_ext << 2);
    j_target  = {pc_plus4[31:28], jump_target, 2'b00};
  end

  // Pick the source chosen by the priority logic in the parent.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_SEQ: next_pc = pc_plus4;
      SEL_BR:  next_pc = br_target;
      SEL_J:   next_pc = j_target;
      SEL_JR:  next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage of the single-cycle core: PC register, run/halt
// control with misaligned-jr fault detection, and retired-instruction counter.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             alu_zero,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [31:0]      imm_ext,
  input  logic [25:0]      jump_target,
  input  logic [31:0]      reg_target,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  logic             state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             taken;
  logic             jr_misaligned;
  pc_sel_e          sel;
  logic [31:0]      next_pc;

  pc_target_calc u_target (
    .pc          (pc_q),
    .sel         (sel),
    .imm_ext     (imm_ext),
    .jump_target (jump_target),
    .reg_target  (reg_target),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  // Resolve the next-PC source by priority: jr, then jump, then taken branch.
  always_comb begin
    taken         = branch & (branch_ne ? ~alu_zero : alu_zero);
    jr_misaligned = jump_reg & (reg_target[1:0] != 2'b00);
    sel           = SEL_SEQ;
    if (jump_reg)   sel = SEL_JR;
    else if (jump)  sel = SEL_J;
    else if (taken) sel = SEL_BR;
  end

  // Next-state logic: halt and fault take precedence over PC updates, stall
  // and the halted state freeze everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    if (state_q == STATE_RUN && !stall) begin
      if (halt_req) begin
        state_d   = STATE_HALT;
        retired_d = retired_q + CNT_W'(1);
      end else if (jr_misaligned) begin
        state_d = STATE_HALT;
        fault_d = 1'b1;
      end else begin
        pc_d      = next_pc;
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous reset to the boot PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= STATE_RUN;
      pc_q      <= RESET_PC;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign halted  = (state_q == STATE_HALT);
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus randomized traffic checked
// against a behavioural model; a 4-bit-counter instance exercises wraparound.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, branch_ne, alu_zero, jump, jump_reg, halt_req;
  logic [31:0] imm_ext, reg_target;
  logic [25:0] jump_target;
  logic [31:0] pc, pc_plus4, s_pc, s_pc_plus4;
  logic        halted, fault, s_halted, s_fault;
  logic [31:0] retired;
  logic [3:0]  s_retired;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_halt, m_fault;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  pc_next_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .jump(jump),
    .jump_reg(jump_reg), .imm_ext(imm_ext), .jump_target(jump_target),
    .reg_target(reg_target), .halt_req(halt_req), .pc(pc),
    .pc_plus4(pc_plus4), .halted(halted), .fault(fault), .retired(retired)
  );

  pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .jump(jump),
    .jump_reg(jump_reg), .imm_ext(imm_ext), .jump_target(jump_target),
    .reg_target(reg_target), .halt_req(halt_req), .pc(s_pc),
    .pc_plus4(s_pc_plus4), .halted(s_halted), .fault(s_fault),
    .retired(s_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halt = 1'b0; m_fault = 1'b0; m_ret = 32'h0;
  endtask

  // Architectural rule of the stage, applied once per rising edge.
  task automatic model_step();
    logic [31:0] seq;
    if (reset || m_halt || stall) return;
    if (halt_req) begin
      m_halt = 1'b1; m_ret = m_ret + 1;
    end else if (jump_reg && (reg_target % 4 != 0)) begin
      m_halt = 1'b1; m_fault = 1'b1;
    end else begin
      seq = m_pc + 32'd4;
      if (jump_reg)       m_pc = reg_target;
      else if (jump)      m_pc = {seq[31:28], jump_target, 2'b00};
      else if (branch && (alu_zero != branch_ne))
                          m_pc = seq + imm_ext * 32'd4;
      else                m_pc = seq;
      m_ret = m_ret + 1;
    end
  endtask

  // Full output check against the model.
  task automatic compare();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("retired", retired, m_ret);
    chk("small_retired", {28'b0, s_retired}, m_ret % 16);
  endtask

  task automatic idle_inputs();
    stall = 0; branch = 0; branch_ne = 0; alu_zero = 0; jump = 0;
    jump_reg = 0; halt_req = 0; imm_ext = 0; jump_target = 0; reg_target = 0;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare();
  endtask

  task automatic jr_to(input logic [31:0] t);
    idle_inputs(); jump_reg = 1; reg_target = t;
    cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1; model_reset();
    @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'h0);
    chk("reset_fault", {31'b0, fault}, 32'h0);
    chk("reset_retired", retired, 32'h0);
    reset = 1'b0;

    // sequential stepping
    cycle(); chk("seq_pc1", pc, 32'h4);
    cycle(); chk("seq_pc2", pc, 32'h8);
    cycle(); chk("seq_pc3", pc, 32'hC);
    chk("seq_retired3", retired, 32'd3);
    repeat (13) cycle();
    chk("retired16", retired, 32'd16);
    chk("small_wrap", {28'b0, s_retired}, 32'd0);

    // reset asserted between edges takes effect immediately
    @(posedge clk); model_step();
    #2 reset = 1'b1;
    #1 chk("midcycle_reset_pc", pc, 32'h0);
    chk("midcycle_reset_ret", retired, 32'h0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    compare();

    // branch taken backwards, then branch_ne not taken
    jr_to(32'h100);
    branch = 1; alu_zero = 1; imm_ext = 32'hFFFF_FFFE;
    cycle(); chk("beq_taken", pc, 32'hFC);
    jr_to(32'h100);
    branch = 1; branch_ne = 1; alu_zero = 1; imm_ext = 32'hFFFF_FFFE;
    cycle(); chk("bne_not_taken", pc, 32'h104);

    // jump beats a taken branch
    jr_to(32'h4000_0010);
    jump = 1; jump_target = 26'h000_0040; branch = 1; alu_zero = 1; imm_ext = 32'h10;
    cycle(); chk("jump_wins", pc, 32'h4000_0100);

    // stall holds everything, then halt retires one
    idle_inputs();
    begin
      logic [31:0] pc0, r0;
      pc0 = m_pc; r0 = m_ret;
      stall = 1; jump = 1; halt_req = 1; jump_target = 26'h3;
      repeat (4) cycle();
      chk("stall_pc", pc, pc0);
      chk("stall_ret", retired, r0);
      stall = 0;
      cycle();
      chk("halt_halted", {31'b0, halted}, 32'h1);
      chk("halt_ret", retired, r0 + 1);
      chk("halt_pc", pc, pc0);
    end
    for (int i = 0; i < 6; i++) begin
      stall = $urandom_range(0, 1); jump = 1; jump_reg = $urandom_range(0, 1);
      reg_target = $urandom; halt_req = 0;
      cycle();
    end
    do_reset();

    // PC wrap at the top of the address space
    jr_to(32'hFFFF_FFFC);
    chk("pc_top", pc, 32'hFFFF_FFFC);
    cycle(); chk("pc_wrap", pc, 32'h0);

    // misaligned jr faults and freezes
    begin
      logic [31:0] r0;
      r0 = m_ret;
      jump_reg = 1; reg_target = 32'h0000_0202;
      cycle();
      chk("fault_flag", {31'b0, fault}, 32'h1);
      chk("fault_halted", {31'b0, halted}, 32'h1);
      chk("fault_pc", pc, 32'h0);
      chk("fault_ret", retired, r0);
      for (int i = 0; i < 5; i++) begin
        jump_reg = 1; reg_target = 32'h40; halt_req = $urandom_range(0, 1);
        cycle();
      end
      chk("fault_frozen_pc", pc, 32'h0);
    end
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        idle_inputs();
        do_reset();
      end else begin
        stall       = ($urandom_range(0, 7) == 0);
        branch      = $urandom_range(0, 1);
        branch_ne   = $urandom_range(0, 1);
        alu_zero    = $urandom_range(0, 1);
        jump        = ($urandom_range(0, 5) == 0);
        jump_reg    = ($urandom_range(0, 7) == 0);
        halt_req    = ($urandom_range(0, 49) == 0);
        imm_ext     = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
        jump_target = 26'($urandom);
        reg_target  = $urandom;
        if ($urandom_range(0, 9) != 0) reg_target[1:0] = 2'b00;
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
